// File: rtl/cpu_pkg.sv
// Shared decode helpers for the ARM32 pipeline stages.
// Field positions, class decode and memory-stage FSM states.
package cpu_pkg;

  localparam int OP_LSB = 21;
  localparam int OP_W   = 7;
  localparam int RD_LSB = 12;
  localparam logic [3:0] NO_RD = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WB
  } mem_state_t;

  function automatic logic [6:0] opcode(
    input logic [31:0] instr
  );
    return instr[OP_LSB +: OP_W];
  endfunction

  function automatic logic [3:0] rd_field(
    input logic [31:0] instr
  );
    return instr[RD_LSB +: 4];
  endfunction

  function automatic logic is_alu(
    input logic [6:0] op
  );
    return !op[6] && (op[5:4] != 2'b10);
  endfunction

  function automatic logic is_mem(
    input logic [6:0] op
  );
    return (op[6:5] == 2'b11) ||
           (op[6:3] == 4'b1000);
  endfunction

  function automatic logic is_load(
    input logic [6:0] op
  );
    return is_mem(op) && op[0];
  endfunction

  function automatic logic is_br(
    input logic [6:0] op
  );
    return op[6:3] == 4'b1001;
  endfunction

endpackage

// File: rtl/mem_handshake.sv
// Data-memory req/ack sequencer with wait counter and load latch.
// Ack in the final wait cycle takes priority over the abort.
module mem_handshake
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        we_i,
  input  logic        ack_i,
  input  logic [31:0] rdata_i,
  output logic        req_o,
  output logic        done_o,
  output logic        err_o,
  output mem_state_t  state_o,
  output logic [31:0] ld_o
);

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  mem_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ld_q, ld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    req_o   = 1'b0;
    done_o  = 1'b0;
    err_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = ACCESS;
      end
      ACCESS: begin
        req_o = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (ack_i) begin
          done_o = 1'b1;
          cnt_d  = '0;
          if (we_i) begin
            state_d = IDLE;
          end else begin
            ld_d    = rdata_i;
            state_d = WB;
          end
        end else if (cnt_q == LAST) begin
          err_o   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WB: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign ld_o    = ld_q;

endmodule

// File: rtl/memory_unit.sv
// Memory stage: stage register, LDR/STR access, forwarding and writeback.
// Stall depends only on state and the captured instruction.
module memory_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic              valid_in,
  input  logic              cond_pass,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic              flush,
  output logic [3:0]        rd,
  output logic              rd_valid,
  output logic [31:0]       fwd_data,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [31:0]       wb_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err,
  output logic [31:0]       instr_output
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] sdata_q, sdata_d;
  logic        valid_q, valid_d;

  mem_state_t  st;
  logic [31:0] ld;
  logic        hs_done, hs_err;
  logic [6:0]  op;
  logic [3:0]  rdf;
  logic        v_alu, v_mem, ld_op;
  logic        st_idle, st_acc, st_wb;

  assign op    = opcode(instr_q);
  assign rdf   = rd_field(instr_q);
  assign ld_op = is_load(op);
  assign v_alu = valid_q && is_alu(op);
  assign v_mem = valid_q && is_mem(op);

  assign st_idle = (st == IDLE);
  assign st_acc  = (st == ACCESS);
  assign st_wb   = (st == WB);

  assign stall = (st_idle && v_mem) || st_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      alu_q   <= '0;
      sdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      alu_q   <= alu_d;
      sdata_q <= sdata_d;
      valid_q <= valid_d;
    end
  end

  // A finished store or aborted access retires here so IDLE
  // does not restart it.
  always_comb begin
    instr_d = instr_q;
    alu_d   = alu_q;
    sdata_d = sdata_q;
    valid_d = valid_q;
    if (!stall) begin
      instr_d = instr_in;
      alu_d   = alu_result;
      sdata_d = store_data;
      valid_d = valid_in && cond_pass && !flush;
    end else if ((hs_done && !ld_op) || hs_err) begin
      valid_d = 1'b0;
    end
  end

  mem_handshake #(
    .MAX_WAIT(MAX_WAIT)
  ) u_hs (
    .clk    (clk),
    .rst    (rst),
    .start_i(st_idle && v_mem),
    .we_i   (!ld_op),
    .ack_i  (mem_ack),
    .rdata_i(mem_rdata),
    .req_o  (mem_req),
    .done_o (hs_done),
    .err_o  (hs_err),
    .state_o(st),
    .ld_o   (ld)
  );

  assign mem_err      = hs_err;
  assign instr_output = instr_q;

  always_comb begin
    rd        = NO_RD;
    rd_valid  = 1'b0;
    fwd_data  = '0;
    wb_en     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      (st_idle && v_alu): begin
        rd       = rdf;
        rd_valid = 1'b1;
        fwd_data = alu_q;
        wb_en    = 1'b1;
        wb_addr  = rdf;
        wb_data  = alu_q;
      end
      (st_wb && valid_q): begin
        rd       = rdf;
        rd_valid = 1'b1;
        fwd_data = ld;
        wb_en    = 1'b1;
        wb_addr  = rdf;
        wb_data  = ld;
      end
      st_acc: begin
        mem_we    = !ld_op;
        mem_addr  = alu_q[ADDR_W-1:0];
        mem_wdata = sdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: directed scenarios then random traffic.
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, alu_result, store_data;
  logic        valid_in, cond_pass, flush;
  logic [3:0]  rd, wb_addr;
  logic        rd_valid, wb_en, stall;
  logic [31:0] fwd_data, wb_data;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] instr_output;

  always #5 clk = ~clk;

  memory_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .valid_in    (valid_in),
    .cond_pass   (cond_pass),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .flush       (flush),
    .rd          (rd),
    .rd_valid    (rd_valid),
    .fwd_data    (fwd_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_err     (mem_err),
    .instr_output(instr_output)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          timeout;
  } mexp_t;
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wexp_t;
  typedef struct {
    int          delay;
    logic [31:0] rdata;
  } resp_t;

  mexp_t mq[$];
  wexp_t wq[$];
  resp_t rq[$];
  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_ALU = 7'b0000100;
  localparam logic [6:0] OP_LDR = 7'b1100001;
  localparam logic [6:0] OP_STR = 7'b1100000;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op,
                                     input logic [3:0] r);
    logic [31:0] x;
    x = $urandom;
    x[27:21] = op;
    x[15:12] = r;
    return x;
  endfunction

  // 0 = no effect, 1 = ALU writeback, 2 = load, 3 = store
  function automatic int kind(input logic [6:0] op);
    if (op[6:5] == 2'b11 || op[6:3] == 4'b1000)
      return op[0] ? 2 : 3;
    if (op[6] == 1'b0 && op[5:4] != 2'b10)
      return 1;
    return 0;
  endfunction

  task automatic issue(input logic [31:0] ins, input bit v,
                       input bit c, input logic [31:0] alu,
                       input logic [31:0] sd, input bit fl,
                       input int delay, input logic [31:0] rdat);
    int n;
    int k;
    resp_t r;
    mexp_t m;
    wexp_t w;
    n = 0;
    @(negedge clk);
    instr_in = ins; valid_in = v; cond_pass = c;
    alu_result = alu; store_data = sd; flush = fl;
    #1;
    while (stall && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("issue_wait", 32'(n >= 100), 0);
    @(posedge clk);
    k = kind(ins[27:21]);
    if (v && c && !fl && k != 0) begin
      if (k == 1) begin
        w.addr = ins[15:12]; w.data = alu;
        wq.push_back(w);
      end else begin
        r.delay = delay; r.rdata = rdat;
        rq.push_back(r);
        m.we = (k == 3); m.addr = alu; m.wdata = sd;
        m.timeout = (delay >= 16);
        mq.push_back(m);
        if (k == 2 && delay < 16) begin
          w.addr = ins[15:12]; w.data = rdat;
          wq.push_back(w);
        end
      end
    end
    #1;
    valid_in = 1'b0;
    flush = 1'b0;
  endtask

  task automatic observe(input int n, output int stall_n,
                         output int wb_at, output int err_at,
                         output int req_n);
    stall_n = 0; wb_at = 0; err_at = 0; req_n = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk); #1;
      if (stall) stall_n++;
      if (mem_req) req_n++;
      if (wb_en && wb_at == 0) wb_at = i;
      if (mem_err && err_at == 0) err_at = i;
    end
  endtask

  // memory responder: acks after the per-request delay
  initial begin
    int cnt;
    bit act;
    resp_t cur;
    mem_ack = 1'b0; mem_rdata = '0; act = 0; cnt = 0;
    cur.delay = 0; cur.rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (!act) begin
          act = 1; cnt = 0;
          if (rq.size() > 0) cur = rq.pop_front();
          else begin
            cur.delay = 999; cur.rdata = '0;
            checks++; errors++;
            $display("FAIL unexpected_req: got req expected none");
          end
        end
        mem_ack = (cnt == cur.delay);
        mem_rdata = mem_ack ? cur.rdata : $urandom;
        cnt++;
      end else begin
        act = 0;
        mem_ack = 1'b0;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents an event
  initial begin
    mexp_t m;
    wexp_t w;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (mem_req && mem_ack) begin
          if (mq.size() == 0) check("unexpected_ack", 1, 0);
          else begin
            m = mq.pop_front();
            check("ack_vs_timeout", 32'(m.timeout), 0);
            check("mem_we", 32'(mem_we), 32'(m.we));
            check("mem_addr", mem_addr, m.addr);
            if (m.we) check("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (mem_err) begin
          if (mq.size() == 0) check("unexpected_err", 1, 0);
          else begin
            m = mq.pop_front();
            check("err_expected", 32'(m.timeout), 1);
          end
        end
        if (wb_en) begin
          if (wq.size() == 0) check("unexpected_wb", 1, 0);
          else begin
            w = wq.pop_front();
            check("wb_addr", 32'(wb_addr), 32'(w.addr));
            check("wb_data", wb_data, w.data);
            check("rd", 32'(rd), 32'(w.addr));
            check("rd_valid", 32'(rd_valid), 1);
            check("fwd_data", fwd_data, w.data);
          end
        end
      end
    end
  end

  initial begin
    int s, wb, er, rq_n, n, dsel, dly;
    rst = 1'b1;
    instr_in = '0; valid_in = 0; cond_pass = 0;
    alu_result = '0; store_data = '0; flush = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd", 32'(rd), 32'hF);
    check("rst_flags", {26'd0, rd_valid, wb_en, stall,
                        mem_req, mem_we, mem_err}, 0);
    check("rst_instr", instr_output, 0);
    check("rst_buses", wb_data | fwd_data | mem_addr | mem_wdata
                       | 32'(wb_addr), 0);
    @(posedge clk); #1 rst = 1'b0;

    issue(mk(OP_ALU, 4'd3), 1, 1, 32'h55, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("t1_rd", 32'(rd), 3);
    check("t1_rd_valid", 32'(rd_valid), 1);
    check("t1_wb_en", 32'(wb_en), 1);
    check("t1_wb_data", wb_data, 32'h55);

    issue(mk(OP_LDR, 4'd5), 1, 1, 32'h200, 0, 0, 1, 32'hDEAD);
    observe(6, s, wb, er, rq_n);
    check("t2_stall", s, 3);
    check("t2_wb_at", wb, 4);
    check("t2_req", rq_n, 2);

    issue(mk(OP_STR, 4'd2), 1, 1, 32'h100, 32'h7, 0, 0, 0);
    observe(4, s, wb, er, rq_n);
    check("t3_wb", wb, 0);
    check("t3_req", rq_n, 1);
    check("t3_stall", s, 2);

    issue(mk(OP_LDR, 4'd6), 1, 1, 32'h300, 0, 0, 99, 0);
    observe(20, s, wb, er, rq_n);
    check("t4_err_at", er, 17);
    check("t4_wb", wb, 0);
    check("t4_req", rq_n, 16);

    issue(mk(OP_LDR, 4'd7), 1, 1, 32'h304, 0, 0, 15, 32'hBEEF);
    observe(20, s, wb, er, rq_n);
    check("t4b_err", er, 0);
    check("t4b_wb_at", wb, 18);
    check("t4b_req", rq_n, 16);

    issue(mk(OP_LDR, 4'd8), 1, 1, 32'h308, 0, 0, 99, 0);
    observe(3, s, wb, er, rq_n);
    check("t5_req_before", rq_n, 2);
    rst = 1'b1;
    @(negedge clk); #1;
    check("t5_req", 32'(mem_req), 0);
    check("t5_rd", 32'(rd), 32'hF);
    check("t5_stall", 32'(stall), 0);
    check("t5_err", 32'(mem_err), 0);
    check("t5_wb", 32'(wb_en), 0);
    @(posedge clk); #1 rst = 1'b0;
    mq.delete(); wq.delete(); rq.delete();

    issue(mk(OP_ALU, 4'd1), 1, 0, 32'h11, 0, 0, 0, 0);
    observe(3, s, wb, er, rq_n);
    check("t6_cond_wb", wb, 0);
    issue(mk(OP_ALU, 4'd1), 1, 1, 32'h22, 0, 1, 0, 0);
    observe(3, s, wb, er, rq_n);
    check("t6_flush_wb", wb, 0);
    issue(mk(OP_STR, 4'd1), 1, 1, 32'h404, 32'h99, 0, 2, 0);
    flush = 1'b1;
    observe(6, s, wb, er, rq_n);
    flush = 1'b0;
    check("t6_access_req", rq_n, 3);
    check("t6_access_done", mq.size(), 0);

    for (int i = 0; i < 200; i++) begin
      dsel = $urandom_range(0, 9);
      if (dsel < 7) dly = $urandom_range(0, 3);
      else if (dsel == 7) dly = 15;
      else if (dsel == 8) dly = 16 + $urandom_range(0, 4);
      else dly = 0;
      issue(mk(7'($urandom_range(0, 127)),
               4'($urandom_range(0, 15))),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) != 0),
            $urandom, $urandom,
            ($urandom_range(0, 9) == 0),
            dly, $urandom);
    end

    n = 0;
    while ((mq.size() != 0 || wq.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    observe(2, s, wb, er, rq_n);
    check("drain_mem", mq.size(), 0);
    check("drain_wb", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
